crf_lite_host_seq: RTL
======================

// Module: crf_lite_host_seq
// PURPOSE
//  AXI4-Lite master sequencer. It drives the config register file's lite slave port from the host side.
//  On a start request it performs these steps in order:
//   - writes the UPSTART register;
//   - waits for interrupt_updone;
//   - reads the UPEND register and checks it;
//   - reports done or error.
//  Used in the SoC-side wrapper and as the bench's stimulus engine for one-frame upscale runs.
// PARAMETERS
//  AXI_DATA_WIDTH  32        lite data width
//  AXI_ADDR_WIDTH  32        lite address width
//  UPSTART_ADDR    'h0       byte address of UPSTART register
//  UPEND_ADDR      'h4       byte address of UPEND register
//  START_VAL       'h1       value written to UPSTART
//  TIMEOUT_CYCLES  1<<20     max cycles in WAIT_IRQ; 0 disables timeout
// PORTS
//  clk               in   1       clock
//  rst_n             in   1       async active-low reset
//  start             in   1       pulse; request one frame run (accepted in IDLE only)
//  busy              out  1       high from start acceptance until done/err pulse
//  done              out  1       1-cycle pulse: run completed OK
//  err               out  1       1-cycle pulse: run failed
//  err_code          out  2       01 BRESP!=OKAY, 10 RRESP!=OKAY or UPEND[0]==0, 11 timeout; held until next start
//  upend_rdata       out  DW      last UPEND read value; held
//  interrupt_updone  in   1       done interrupt from register file
//  m_axi_awvalid/awready  out/in 1       write address handshake
//  m_axi_awaddr      out  AW      write address
//  m_axi_awprot      out  3       tied 3'b000
//  m_axi_wvalid/wready    out/in 1       write data handshake
//  m_axi_wdata       out  DW      write data
//  m_axi_wstrb       out  DW/8    all ones
//  m_axi_bvalid/bready    in/out 1       write response handshake
//  m_axi_bresp       in   2       write response
//  m_axi_arvalid/arready  out/in 1       read address handshake
//  m_axi_araddr      out  AW      read address
//  m_axi_arprot      out  3       tied 3'b000
//  m_axi_rvalid/rready    in/out 1       read data handshake
//  m_axi_rdata       in   DW      read data
//  m_axi_rresp       in   2       read response
// BEHAVIOUR
//  Reset: all m_axi valids/readies 0, addr/data 0, busy/done/err 0, err_code 0, upend_rdata 0, state IDLE.
//  FSM: IDLE -> WR -> WAIT_B -> WAIT_IRQ -> RD -> WAIT_R -> IDLE.
//  IDLE:
//   - start=1 is accepted; busy=1 next cycle.
//   - Entering WR, awvalid and wvalid rise together in the cycle after acceptance.
//   - awaddr=UPSTART_ADDR, wdata=START_VAL.
//  WR:
//   - awvalid and wvalid each drop the cycle after their own handshake; AW and W may complete in either order or together.
//   - Payloads stay stable while valid is high.
//   - Move to WAIT_B once both have completed.
//  WAIT_B:
//   - bready=1; leave on bvalid.
//   - If bresp!=2'b00: err pulse, err_code=01, go to IDLE.
//   - Otherwise go to WAIT_IRQ.
//  IRQ capture: sticky irq_seen, cleared at start acceptance, set by interrupt_updone=1 in any non-IDLE state.
//   - An interrupt arriving during WR/WAIT_B is therefore not lost.
//   - interrupt_updone in IDLE is ignored.
//  WAIT_IRQ:
//   - Cycle counter starts at 0 on entry.
//   - When irq_seen is set (or interrupt_updone=1 this cycle), go to RD.
//   - If the counter reaches TIMEOUT_CYCLES-1 first: err pulse, err_code=11, go to IDLE.
//   - If irq and timeout coincide, irq wins.
//  RD: arvalid=1, araddr=UPEND_ADDR; drops the cycle after arready; then WAIT_R.
//  WAIT_R:
//   - rready=1; on rvalid, upend_rdata<=rdata.
//   - rresp!=OKAY or rdata[0]==0: err pulse, err_code=10.
//   - Otherwise done pulse.
//   - Either way return to IDLE.
//  Pulse timing: done/err assert for exactly 1 cycle, in the cycle after the terminating handshake. busy drops in the same cycle.
//  Only one outstanding transaction; the W/AW and AR phases never overlap.
//  start while busy is ignored (no queueing).
//  Async reset mid-transaction: all valids drop immediately and the FSM returns to IDLE. No completion pulse is issued.
// TESTING
//  1 Nominal:
//     - stimulus: start; slave zero-wait; irq 20 cycles later; rdata='h1.
//     - response: AW/W at UPSTART_ADDR/'h1, AR at UPEND_ADDR, done 1 cycle, err_code 0, upend_rdata='h1.
//  2 Skewed AW/W:
//     - stimulus: awready 3 cycles before wready.
//     - response: awvalid drops after its handshake, wdata held stable, single B handshake.
//  3 Early irq:
//     - stimulus: interrupt_updone pulsed while bvalid held off 5 cycles.
//     - response: no wait in WAIT_IRQ; AR issued right after B; done.
//  4 Errors:
//     - bresp=2'b10 -> err, err_code=01, no AR issued.
//     - rresp=OKAY with rdata='h0 -> err, err_code=10.
//  5 Timeout:
//     - stimulus: TIMEOUT_CYCLES=16, no irq.
//     - response: err exactly 16 cycles after WAIT_IRQ entry, err_code=11.
//  6 Reset and busy:
//     - start re-pulsed while busy -> ignored.
//     - rst_n low during WAIT_R -> all outputs at reset values; next start runs cleanly.

Source files
------------

// File: rtl/crf_lite_host_seq_if.sv
// AXI4-Lite bundle between the host sequencer (master) and the register file (slave).
// Latency: none, wires only.
// Backpressure: standard valid/ready on each of the AW, W, B, AR and R channels.
// Ports: awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp,
//        arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp.
interface crf_lite_host_seq_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic                          awvalid;
  logic                          awready;
  logic [AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                    awprot;
  logic                          wvalid;
  logic                          wready;
  logic [AXI_DATA_WIDTH-1:0]     wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                          bvalid;
  logic                          bready;
  logic [1:0]                    bresp;
  logic                          arvalid;
  logic                          arready;
  logic [AXI_ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                    arprot;
  logic                          rvalid;
  logic                          rready;
  logic [AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                    rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/crf_lite_host_seq.sv
// Host-side AXI4-Lite sequencer: write UPSTART, wait for updone irq, read and check UPEND.
// Latency: AW/W valid one cycle after start; done/err one cycle after the final handshake.
// Backpressure: holds each valid (payload stable) until ready; one transaction outstanding.
// Ports: clk, rst_n; start in, busy/done/err/err_code/upend_rdata out;
//        interrupt_updone in; m_axi = lite master side of crf_lite_host_seq_if.
module crf_lite_host_seq #(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] UPSTART_ADDR   = 'h0,
  parameter logic [AXI_ADDR_WIDTH-1:0] UPEND_ADDR     = 'h4,
  parameter logic [AXI_DATA_WIDTH-1:0] START_VAL      = 'h1,
  parameter int                        TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [AXI_DATA_WIDTH-1:0] upend_rdata,
  input  logic                      interrupt_updone,
  crf_lite_host_seq_if.master       m_axi
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR       = 3'd1;
  localparam logic [2:0] WAIT_B   = 3'd2;
  localparam logic [2:0] WAIT_IRQ = 3'd3;
  localparam logic [2:0] RD       = 3'd4;
  localparam logic [2:0] WAIT_R   = 3'd5;

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]       state;
  logic             aw_done;
  logic             w_done;
  logic             irq_seen;
  logic [CNT_W-1:0] wait_cnt;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid && m_axi.wready;

  // Response readies follow the state register so reset drops them at once.
  assign m_axi.bready = (state == WAIT_B);
  assign m_axi.rready = (state == WAIT_R);
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wstrb  = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.wdata   <= '0;
      m_axi.araddr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'b00;
      upend_rdata   <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      irq_seen      <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // Sticky capture so an irq that beats the B response is not lost.
      if (state != IDLE && interrupt_updone)
        irq_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state         <= WR;
            busy          <= 1'b1;
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            m_axi.awaddr  <= UPSTART_ADDR;
            m_axi.wdata   <= START_VAL;
            err_code      <= 2'b00;
            irq_seen      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end
        end

        WR: begin
          if (aw_hs) begin
            m_axi.awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi.wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          // AW and W may finish in either order or in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs))
            state <= WAIT_B;
        end

        WAIT_B: begin
          if (m_axi.bvalid) begin
            if (m_axi.bresp != 2'b00) begin
              err      <= 1'b1;
              err_code <= 2'b01;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              state    <= WAIT_IRQ;
              wait_cnt <= '0;
            end
          end
        end

        WAIT_IRQ: begin
          // irq is tested first so it wins a tie with the timeout.
          if (irq_seen || interrupt_updone) begin
            state         <= RD;
            m_axi.arvalid <= 1'b1;
            m_axi.araddr  <= UPEND_ADDR;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            state         <= WAIT_R;
          end
        end

        WAIT_R: begin
          if (m_axi.rvalid) begin
            upend_rdata <= m_axi.rdata;
            if (m_axi.rresp != 2'b00 || !m_axi.rdata[0]) begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end else begin
              done <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
